// File: rtl/hilo_mac_reg.sv
// HI/LO special-register unit: direct MTHI/MTLO-style writes with write-through read,
// plus a multi-cycle multiply-accumulate/subtract into the {HI,LO} pair.
module hilo_mac_reg #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_hi_en,
    input  logic              wr_lo_en,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              req_ready,
    input  logic              flush,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_ACC  = 2'b10
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [DATA_W-1:0]     a_r;
    logic [DATA_W-1:0]     b_r;
    logic [1:0]            op_r;
    logic [2*DATA_W-1:0]   prod_r;
    logic [DATA_W-1:0]     hi_r;
    logic [DATA_W-1:0]     lo_r;
    logic                  done_r;
    logic                  idle_s;
    logic                  accept_s;
    logic [2*DATA_W-1:0]   a_ext_s;
    logic [2*DATA_W-1:0]   b_ext_s;
    logic [2*DATA_W-1:0]   prod_s;
    logic [2*DATA_W-1:0]   acc_s;

    assign idle_s    = (state_r == ST_IDLE);
    assign req_ready = rst & idle_s & ~wr_en & ~flush;
    assign accept_s  = req_valid & req_ready;
    assign busy_o    = ~idle_s;
    assign done_o    = done_r;

    // Sign-extending to full width first makes one truncated multiply serve both signednesses.
    always_comb begin
        a_ext_s = {{DATA_W{1'b0}}, a_r};
        b_ext_s = {{DATA_W{1'b0}}, b_r};
        if (op_r[0]) begin
            a_ext_s = {{DATA_W{a_r[DATA_W-1]}}, a_r};
            b_ext_s = {{DATA_W{b_r[DATA_W-1]}}, b_r};
        end else begin
            a_ext_s = {{DATA_W{1'b0}}, a_r};
            b_ext_s = {{DATA_W{1'b0}}, b_r};
        end
        prod_s = a_ext_s * b_ext_s;
        if (op_r[1]) begin
            acc_s = {hi_r, lo_r} - prod_r;
        end else begin
            acc_s = {hi_r, lo_r} + prod_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_MUL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_ACC;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_ACC:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // HI/LO, operand latches, countdown, product and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r   <= {DATA_W{1'b0}};
            lo_r   <= {DATA_W{1'b0}};
            a_r    <= {DATA_W{1'b0}};
            b_r    <= {DATA_W{1'b0}};
            op_r   <= 2'b00;
            cnt_r  <= {CNT_W{1'b0}};
            prod_r <= {(2*DATA_W){1'b0}};
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (wr_en) begin
                        if (wr_hi_en) hi_r <= hi_i;
                        if (wr_lo_en) lo_r <= lo_i;
                    end
                    if (accept_s) begin
                        a_r   <= op_a;
                        b_r   <= op_b;
                        op_r  <= req_op;
                        cnt_r <= CNT_W'(MUL_CYCLES - 1);
                    end
                end
                ST_MUL: begin
                    if (!flush) begin
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            prod_r <= prod_s;
                        end else begin
                            cnt_r <= cnt_r - CNT_W'(1);
                        end
                    end
                end
                ST_ACC: begin
                    // A flush here cancels the commit, so HI/LO keep their old values.
                    if (!flush) begin
                        {hi_r, lo_r} <= acc_s;
                        done_r       <= 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // Readers see the incoming value of a half being written this cycle.
    always_comb begin
        hi_o = hi_r;
        lo_o = lo_r;
        if (!rst) begin
            hi_o = {DATA_W{1'b0}};
            lo_o = {DATA_W{1'b0}};
        end else begin
            hi_o = (idle_s && wr_en && wr_hi_en) ? hi_i : hi_r;
            lo_o = (idle_s && wr_en && wr_lo_en) ? lo_i : lo_r;
        end
    end

endmodule

// File: tb/tb_hilo_mac_reg.sv
// Directed bench for hilo_mac_reg: accumulate results flow through a scoreboard queue
// checked by a monitor on done_o; control/read-path checks are made inline.
module tb_hilo_mac_reg;
    localparam int W  = 32;
    localparam int MC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, wr_hi_en, wr_lo_en;
    logic [W-1:0]  hi_i, lo_i;
    logic          req_valid;
    logic [1:0]    req_op;
    logic [W-1:0]  op_a, op_b;
    logic          req_ready, flush, busy_o, done_o;
    logic [W-1:0]  hi_o, lo_o;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [2*W-1:0] exp_q[$];

    hilo_mac_reg #(.DATA_W(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_hi_en(wr_hi_en), .wr_lo_en(wr_lo_en),
        .hi_i(hi_i), .lo_i(lo_i), .req_valid(req_valid), .req_op(req_op),
        .op_a(op_a), .op_b(op_b), .req_ready(req_ready), .flush(flush),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done_o pulse must match the oldest expected {HI,LO}.
    always @(negedge clk) begin
        if (rst === 1'b1 && done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got %h%h expected no result", hi_o, lo_o);
            end else begin
                check("acc_result", {hi_o, lo_o}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [W-1:0] h, input logic [W-1:0] l, input logic he, input logic le);
        wr_en = 1'b1; wr_hi_en = he; wr_lo_en = le; hi_i = h; lo_i = l;
        tick();
        wr_en = 1'b0; wr_hi_en = 1'b0; wr_lo_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        req_valid = 1'b1; req_op = op; op_a = a; op_b = b;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            n_cmp++; n_err++;
            $display("FAIL issue_timeout: got req_ready=0 expected 1");
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (done_o !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: got done_o=0 expected 1");
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_hi_en = 1'b0; wr_lo_en = 1'b0;
        hi_i = '0; lo_i = '0; req_valid = 1'b1; req_op = 2'b00; op_a = '0; op_b = '0;
        flush = 1'b0;
        tick(); tick();
        check("rst_hi", 64'(hi_o), 64'h0);
        check("rst_lo", 64'(lo_o), 64'h0);
        check("rst_ctrl", {61'h0, busy_o, done_o, req_ready}, 64'h0);
        req_valid = 1'b0;
        rst = 1'b1;
        tick();

        // 1: write-through of HI only
        wr_en = 1'b1; wr_hi_en = 1'b1; wr_lo_en = 1'b0;
        hi_i = 32'hDEAD_BEEF; lo_i = 32'h1234_5678;
        #1;
        check("wt_hi", 64'(hi_o), 64'hDEAD_BEEF);
        check("wt_lo", 64'(lo_o), 64'h0);
        tick();
        wr_en = 1'b0; wr_hi_en = 1'b0;
        #1;
        check("stored_hilo", {hi_o, lo_o}, 64'hDEAD_BEEF_0000_0000);

        // 2: MADDU with carry from LO into HI, plus latency
        wr(32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        issue(2'b00, 32'h1, 32'h1);
        exp_q.push_back(64'h0000_0001_0000_0000);
        check("busy_after_accept", {63'h0, busy_o}, 64'h1);
        check("ready_while_busy", {63'h0, req_ready}, 64'h0);
        check("hold_during_mul", {hi_o, lo_o}, 64'h0000_0000_FFFF_FFFF);
        repeat (MC) tick();
        check("no_early_done", {63'h0, done_o}, 64'h0);
        tick();
        check("done_latency", {62'h0, done_o, busy_o}, 64'h2);
        tick();

        // 3: signed/unsigned subtract and add
        wr(32'h0, 32'h0, 1'b1, 1'b1);
        issue(2'b11, 32'hFFFF_FFFF, 32'h2);
        exp_q.push_back(64'h0000_0000_0000_0002);
        wait_done();
        issue(2'b01, 32'hFFFF_FFFF, 32'h2);
        exp_q.push_back(64'h0);
        wait_done();
        issue(2'b10, 32'h1, 32'h1);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        wait_done();
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp_q.push_back(64'hFFFF_FFFE_0000_0000);
        wait_done();

        // 4: flush in IDLE blocks acceptance; flush in MUL cancels
        wr(32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1);
        flush = 1'b1; req_valid = 1'b1; req_op = 2'b01; op_a = 32'h3; op_b = 32'h4;
        #1;
        check("flush_idle_ready", {63'h0, req_ready}, 64'h0);
        tick();
        check("flush_idle_busy", {63'h0, busy_o}, 64'h0);
        flush = 1'b0;
        issue(2'b01, 32'h3, 32'h4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy_drop", {63'h0, busy_o}, 64'h0);
        check("flush_hold", {hi_o, lo_o}, 64'h1111_1111_2222_2222);
        repeat (MC + 2) tick();
        check("flush_no_done", {63'h0, done_o}, 64'h0);
        issue(2'b00, 32'h3, 32'h4);
        exp_q.push_back(64'h1111_1111_2222_222E);
        wait_done();

        // 5: write wins over a same-cycle request
        wr_en = 1'b1; wr_hi_en = 1'b1; wr_lo_en = 1'b1;
        hi_i = 32'hA5A5_A5A5; lo_i = 32'h5A5A_5A5A;
        req_valid = 1'b1; req_op = 2'b00; op_a = 32'h1; op_b = 32'h1;
        #1;
        check("wr_blocks_ready", {63'h0, req_ready}, 64'h0);
        tick();
        wr_en = 1'b0; wr_hi_en = 1'b0; wr_lo_en = 1'b0;
        #1;
        check("ready_after_wr", {63'h0, req_ready}, 64'h1);
        check("wr_applied", {hi_o, lo_o}, 64'hA5A5_A5A5_5A5A_5A5A);
        tick();
        req_valid = 1'b0;
        exp_q.push_back(64'hA5A5_A5A5_5A5A_5A5B);
        check("busy_after_wr_req", {63'h0, busy_o}, 64'h1);
        wait_done();

        // 6: async reset during ACC
        issue(2'b00, 32'h2, 32'h3);
        repeat (MC) tick();
        rst = 1'b0;
        #1;
        check("rst_acc_out", {hi_o, lo_o}, 64'h0);
        check("rst_acc_ctrl", {62'h0, busy_o, done_o}, 64'h0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_busy", {63'h0, busy_o}, 64'h0);
        check("post_rst_hilo", {hi_o, lo_o}, 64'h0);
        tick(); tick();

        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
